// File: rtl/iter_divider_pkg.sv
// Shared types and helpers for the iterative divider.
package iter_divider_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Iteration counter width: clog2 of the operand width (at least 1 bit).
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/iter_divider_adder.sv
// Plain W-bit adder with carry-in/carry-out; used for trial subtraction and two's-complement negation.
module iter_divider_adder #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/iter_divider.sv
// Multi-cycle restoring divider (DIV/DIVU/REM/REMU) with valid/ready on both sides and a pass-through tag.
module iter_divider
  import iter_divider_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned TAG_WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 rst_aL,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_dividend,
  input  logic [WIDTH-1:0]     in_divisor,
  input  logic                 in_signed,
  input  logic                 in_want_rem,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_result,
  output logic [TAG_WIDTH-1:0] out_tag
);

  localparam int unsigned CW = cnt_width(WIDTH);

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [WIDTH-1:0]     rem;
  logic [WIDTH-1:0]     quo;
  logic [WIDTH-1:0]     dvs;
  logic                 sgn;
  logic                 want_rem;
  logic                 q_neg;
  logic                 r_neg;
  logic [TAG_WIDTH-1:0] tag;

  logic [WIDTH-1:0] neg_a_src, neg_a, neg_b;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   shifted, trial;
  logic             trial_cout;
  logic             is_div0, is_ovf;
  logic [WIDTH-1:0] fix_val, fix_res;
  logic             fix_neg;
  logic             unused_neg_a_cout, unused_neg_b_cout, unused_trial_msb;

  // One negator is shared: dividend magnitude at accept, result sign fixup afterwards.
  assign neg_a_src = (state == IDLE) ? in_dividend : (want_rem ? rem : quo);

  iter_divider_adder #(.W(WIDTH)) u_neg_a (
    .a(~neg_a_src), .b({WIDTH{1'b0}}), .cin(1'b1), .sum(neg_a), .cout(unused_neg_a_cout)
  );

  iter_divider_adder #(.W(WIDTH)) u_neg_b (
    .a(~in_divisor), .b({WIDTH{1'b0}}), .cin(1'b1), .sum(neg_b), .cout(unused_neg_b_cout)
  );

  assign abs_a = (in_signed && in_dividend[WIDTH-1]) ? neg_a : in_dividend;
  assign abs_b = (in_signed && in_divisor[WIDTH-1])  ? neg_b : in_divisor;

  // Partial remainder stays below the divisor, so only its low WIDTH bits need storing.
  assign shifted = {rem, quo[WIDTH-1]};

  iter_divider_adder #(.W(WIDTH + 1)) u_trial (
    .a(shifted), .b(~{1'b0, dvs}), .cin(1'b1), .sum(trial), .cout(trial_cout)
  );
  assign unused_trial_msb = trial[WIDTH];

  assign is_div0 = (in_divisor == '0);
  assign is_ovf  = in_signed && (in_dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (in_divisor == '1);

  assign fix_val = want_rem ? rem : quo;
  assign fix_neg = sgn && (want_rem ? r_neg : q_neg);
  assign fix_res = fix_neg ? neg_a : fix_val;

  always_ff @(posedge clk) begin
    if (!rst_aL) begin
      state      <= IDLE;
      cnt        <= '0;
      rem        <= '0;
      quo        <= '0;
      dvs        <= '0;
      sgn        <= 1'b0;
      want_rem   <= 1'b0;
      q_neg      <= 1'b0;
      r_neg      <= 1'b0;
      tag        <= '0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_tag    <= '0;
    end else if (flush) begin
      state     <= IDLE;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            tag      <= in_tag;
            sgn      <= in_signed;
            want_rem <= in_want_rem;
            q_neg    <= in_dividend[WIDTH-1] ^ in_divisor[WIDTH-1];
            r_neg    <= in_dividend[WIDTH-1];
            in_ready <= 1'b0;
            if (is_div0 || is_ovf) begin
              // Divide-by-zero and signed overflow resolve without iterating.
              if (is_div0) out_result <= in_want_rem ? in_dividend : '1;
              else         out_result <= in_want_rem ? '0 : in_dividend;
              out_tag   <= in_tag;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              rem   <= '0;
              quo   <= abs_a;
              dvs   <= abs_b;
              cnt   <= CW'(WIDTH - 1);
              state <= CALC;
            end
          end
        end
        CALC: begin
          rem <= trial_cout ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], trial_cout};
          cnt <= cnt - CW'(1);
          if (cnt == '0) state <= FIXUP;
        end
        FIXUP: begin
          out_result <= fix_res;
          out_tag    <= tag;
          out_valid  <= 1'b1;
          state      <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iter_divider.sv
// Self-checking bench for iter_divider: directed cases, random ops vs arithmetic model, backpressure, flush, reset.
module tb_iter_divider;

  localparam int unsigned W  = 32;
  localparam int unsigned TW = 6;

  logic          clk = 1'b0;
  logic          rst_aL;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_dividend;
  logic [W-1:0]  in_divisor;
  logic          in_signed;
  logic          in_want_rem;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_result;
  logic [TW-1:0] out_tag;

  int errors = 0;
  int checks = 0;

  iter_divider #(.WIDTH(W), .TAG_WIDTH(TW)) dut (
    .clk(clk), .rst_aL(rst_aL), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_dividend(in_dividend), .in_divisor(in_divisor),
    .in_signed(in_signed), .in_want_rem(in_want_rem), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  // Reference: RISC-V M-extension semantics with plain arithmetic.
  function automatic logic [W-1:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic s, input logic r);
    logic [W-1:0] q, m;
    if (b == 0) begin
      q = '1; m = a;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a; m = '0;
    end else if (s) begin
      q = W'($signed(a) / $signed(b));
      m = W'($signed(a) % $signed(b));
    end else begin
      q = a / b; m = a % b;
    end
    return r ? m : q;
  endfunction

  function automatic int ref_lat(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    if (b == 0) return 1;
    if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return W + 2;
  endfunction

  // Present one request, count edges from accept to out_valid, capture the result.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input logic r, input logic [TW-1:0] t,
                        output logic [W-1:0] res, output logic [TW-1:0] otag, output int lat);
    @(negedge clk);
    in_dividend = a; in_divisor = b; in_signed = s; in_want_rem = r; in_tag = t;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    res  = out_result;
    otag = out_tag;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_result !== '0) begin errors++; $display("FAIL reset_out_result got=%h exp=0", out_result); end
    checks++; if (out_tag !== '0) begin errors++; $display("FAIL reset_out_tag got=%h exp=0", out_tag); end
  endtask

  task automatic check_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s, input logic r, input logic [TW-1:0] t);
    logic [W-1:0]  res;
    logic [TW-1:0] otag;
    int            lat;
    logic [W-1:0]  exp_res;
    int            exp_lat;
    exp_res = ref_div(a, b, s, r);
    exp_lat = ref_lat(a, b, s);
    run_op(a, b, s, r, t, res, otag, lat);
    checks++;
    if (res !== exp_res) begin
      errors++;
      $display("FAIL %s_result a=%h b=%h s=%b r=%b got=%h exp=%h", name, a, b, s, r, res, exp_res);
    end
    checks++;
    if (lat !== exp_lat) begin
      errors++;
      $display("FAIL %s_latency a=%h b=%h got=%0d exp=%0d", name, a, b, lat, exp_lat);
    end
    checks++;
    if (otag !== t) begin
      errors++;
      $display("FAIL %s_tag got=%h exp=%h", name, otag, t);
    end
  endtask

  task automatic test_directed();
    check_op("divu_100_7",   32'd100, 32'd7, 1'b0, 1'b0, 6'h15);
    check_op("remu_100_7",   32'd100, 32'd7, 1'b0, 1'b1, 6'h2A);
    check_op("div_m7_2",     32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 6'h01);
    check_op("rem_m7_2",     32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, 6'h02);
    check_op("div_7_m2",     32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0, 6'h03);
    check_op("rem_7_m2",     32'd7, 32'hFFFF_FFFE, 1'b1, 1'b1, 6'h04);
    check_op("divu_5_0",     32'd5, 32'd0, 1'b0, 1'b0, 6'h05);
    check_op("remu_5_0",     32'd5, 32'd0, 1'b0, 1'b1, 6'h06);
    check_op("div_ovf",      32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 6'h07);
    check_op("rem_ovf",      32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 6'h08);
    check_op("divu_max_1",   32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 6'h09);
    check_op("divu_ovfpat",  32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 6'h0A);
  endtask

  task automatic test_random();
    logic [W-1:0]  a, b;
    logic          s, r;
    logic [TW-1:0] t;
    for (int i = 0; i < 40; i++) begin
      a = $urandom; b = $urandom;
      s = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      t = TW'($urandom);
      case ($urandom_range(0, 5))
        0: begin a = W'($urandom_range(0, 1000)); b = W'($urandom_range(1, 20)); end
        1: b = '0;
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3: b = W'($urandom_range(0, 255)) | 32'h8000_0000;
        default: ;
      endcase
      check_op("random", a, b, s, r, t);
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0]  r0;
    logic [TW-1:0] t0;
    int            lat;
    logic          bad_hold;
    bad_hold = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    in_dividend = 32'd1000; in_divisor = 32'd9; in_signed = 1'b0; in_want_rem = 1'b0; in_tag = 6'h3C;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    r0 = out_result; t0 = out_tag;
    checks++;
    if (r0 !== 32'd111 || t0 !== 6'h3C) begin
      errors++; $display("FAIL bp_first_result got=%h/%h exp=%h/%h", r0, t0, 32'd111, 6'h3C);
    end
    // Offer a second op while stalled in DONE; it must wait for the handshake.
    in_dividend = 32'd50; in_divisor = 32'd5; in_want_rem = 1'b0; in_tag = 6'h11;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || out_result !== r0 || out_tag !== t0 || in_ready !== 1'b0) bad_hold = 1'b1;
    end
    checks++;
    if (bad_hold !== 1'b0) begin
      errors++; $display("FAIL bp_hold_stable got=%b exp=0", bad_hold);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_after_handshake got=v%b/r%b exp=v0/r1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    checks++;
    if (out_result !== 32'd10 || out_tag !== 6'h11 || lat !== 34) begin
      errors++;
      $display("FAIL bp_next_op got=%h/%h lat=%0d exp=%h/%h lat=34", out_result, out_tag, lat, 32'd10, 6'h11);
    end
    @(posedge clk); #1;
  endtask

  // Abort an op mid-CALC by flush (use_reset=0) or reset (use_reset=1).
  task automatic test_abort(input logic use_reset, input int iters);
    logic stale;
    stale = 1'b0;
    @(negedge clk);
    in_dividend = 32'd123456; in_divisor = 32'd7; in_signed = 1'b0; in_want_rem = 1'b0; in_tag = 6'h2F;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (iters) @(posedge clk);
    @(negedge clk);
    if (use_reset) rst_aL = 1'b0; else flush = 1'b1;
    // A request offered alongside the abort must be ignored.
    in_dividend = 32'd5; in_divisor = 32'd0; in_tag = 6'h33; in_valid = 1'b1;
    @(posedge clk); #1;
    rst_aL = 1'b1; flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL abort%0d_state got=r%b/v%b exp=r1/v0", use_reset, in_ready, out_valid);
    end
    if (use_reset) begin
      checks++;
      if (out_result !== '0 || out_tag !== '0) begin
        errors++; $display("FAIL abort_reset_outputs got=%h/%h exp=0/0", out_result, out_tag);
      end
    end
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) stale = 1'b1;
    end
    checks++;
    if (stale !== 1'b0) begin
      errors++; $display("FAIL abort%0d_stale got=%b exp=0", use_reset, stale);
    end
    check_op("after_abort", 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 6'h1E);
  endtask

  task automatic test_flush_done();
    logic stale;
    stale = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    in_dividend = 32'd9; in_divisor = 32'd0; in_signed = 1'b0; in_want_rem = 1'b0; in_tag = 6'h0C;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_done got=v%b/r%b exp=v0/r1", out_valid, in_ready);
    end
    repeat (5) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) stale = 1'b1;
    end
    checks++;
    if (stale !== 1'b0) begin
      errors++; $display("FAIL flush_done_stale got=%b exp=0", stale);
    end
  endtask

  initial begin
    rst_aL = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_dividend = '0; in_divisor = '0; in_signed = 1'b0; in_want_rem = 1'b0; in_tag = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst_aL = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_abort(1'b0, 10);
    test_abort(1'b1, 20);
    test_flush_done();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/iter_divider.md
Name: iter_divider

Overview:
Multi-cycle iterative restoring divider for the M-extension DIV/DIVU/REM/REMU ops in the integer execute cluster. It is the inverse-direction companion to the ripple adder. Each iteration does one trial subtraction through an adder instance (b inverted, cin=1) and retires one quotient bit. It sits behind the issue queue with a valid/ready handshake on both sides and carries an opaque ROB tag.

Parameters:
WIDTH, 32, operand/result width in bits
TAG_WIDTH, 6, width of the pass-through ROB tag

Ports:
clk  input  1  clock, all state updates on rising edge
rst_aL  input  1  synchronous active-low reset
flush  input  1  pipeline flush; kills any in-flight or completed-unaccepted op
in_valid  input  1  request valid
in_ready  output  1  divider can accept a request (high only in IDLE)
in_dividend  input  WIDTH  rs1 value
in_divisor  input  WIDTH  rs2 value
in_signed  input  1  1 = DIV/REM, 0 = DIVU/REMU
in_want_rem  input  1  1 = return remainder, 0 = return quotient
in_tag  input  TAG_WIDTH  ROB tag, returned unchanged
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_result  output  WIDTH  quotient or remainder
out_tag  output  TAG_WIDTH  tag of the completing op

Behaviour:
- Reset (rst_aL=0 at a clk edge): state=IDLE; in_ready=1, out_valid=0, out_result=0, out_tag=0, iteration counter=0. Reset wins over every other input, including mid-operation.
- States:
  - IDLE: accept when in_valid && in_ready.
    - Special cases go straight to DONE.
    - Otherwise go to CALC.
  - CALC: performs WIDTH iterations, then goes to FIXUP.
  - FIXUP: applies signs, then goes to DONE.
  - DONE: holds out_valid=1 until out_valid && out_ready, then returns to IDLE.
- Capture on accept:
  - Latch tag, op flags and |dividend|, |divisor|. Absolute values are taken only when in_signed=1; negation is ~x+1 via the adder.
  - Record q_neg = sign(a)^sign(b) and r_neg = sign(a).
- Special cases, resolved in IDLE with latency 1 cycle (accept edge to out_valid):
  - Divisor == 0: quotient = all ones; remainder = dividend.
  - Signed, dividend == 100..0, divisor == all ones: quotient = dividend; remainder = 0.
- CALC iteration (one per cycle, counter WIDTH-1 down to 0):
  - Partial remainder R is WIDTH+1 bits; shift {R, Q} left by 1.
  - Trial = R - D via a (WIDTH+1)-bit adder with b=~{0,D} and cin=1.
  - If the trial carry-out is 1, then R = trial and Q[0] = 1; else R is kept and Q[0] = 0.
- FIXUP:
  - Quotient is negated if q_neg && signed.
  - Remainder is negated if r_neg && signed.
  - Select by want_rem.
- Normal latency: accept edge to out_valid = WIDTH+2 cycles (34 for WIDTH=32).
- in_ready = (state==IDLE). There is no accept in DONE, even on the same cycle the result is taken; the next accept is no earlier than the cycle after the handshake.
- Backpressure: in DONE with out_ready=0, out_result and out_tag stay stable indefinitely.
- Flush:
  - On the next edge the state goes to IDLE and out_valid=0; the op produces no output.
  - A request presented with flush=1 is not accepted.
  - Reset has priority over flush.
- Result width: all arithmetic is modulo 2^WIDTH; the overflow case follows the RISC-V spec exactly as listed above.
- Outputs are registered; no combinational path exists from in_* to out_*.

Decomposition:
- Shared package holds the FSM state enum (IDLE, CALC, FIXUP, DONE) and the constant for counter width, clog2(WIDTH).
- Trial subtraction and negation reuse the existing adder module (WIDTH+1 and WIDTH instances); no new sub-module.

Test Plan:
- Unsigned 100 / 7, want_rem=0, then want_rem=1 -> out_result 14, then 2; out_valid exactly 34 cycles after accept; tag echoed.
- Signed -7 / 2 -> quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1); signed 7 / -2 -> quotient -3, remainder 1.
- Divide by zero: DIVU 5 / 0 -> 0xFFFFFFFF; REMU 5 / 0 -> 5; out_valid 1 cycle after accept.
- Signed overflow 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0; 1-cycle latency.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid, out_result and out_tag stable; in_ready=0 throughout. After the handshake, a new op is accepted the following cycle.
- Flush at iteration 10, and separately rst_aL=0 at iteration 20 -> next cycle IDLE, in_ready=1, out_valid=0, no stale result. A subsequent 0xFFFFFFFF / 1 unsigned returns 0xFFFFFFFF.
